// File: rtl/entry_seq_pkg.sv
// entry_seq_pkg
// Shared types and helpers for the digit-entry sequencer.
//   seq_state_e : sequencer FSM states
//   led_step()  : 1-based step number shown on the led output
package entry_seq_pkg;

  typedef enum logic [1:0] {
    LOAD_WAIT   = 2'd0,
    LOAD_STROBE = 2'd1,
    RESULT      = 2'd2
  } seq_state_e;

  // In the result phase the step count continues after the last operand
  // digit, so the user sees one unbroken numbering for the whole session.
  function automatic int unsigned led_step(
    input logic        in_result,
    input int unsigned operand,
    input int unsigned digit,
    input int unsigned digits,
    input int unsigned num_operands
  );
    if (in_result) begin
      return num_operands * digits + digit + 1;
    end
    return operand * digits + digit + 1;
  endfunction

endpackage

// File: rtl/entry_sequencer_button_edge.sv
// button_edge
// Synchronises a raw push-button into the clk domain and produces a
// one-cycle press pulse per rising edge. No debounce filter.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   boton : raw asynchronous button, active-high
//   press : one-cycle pulse per rising edge of the synchronised button
module button_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // press is registered so it appears one edge after sync_out rises; this
  // places the accepted strobe SYNC_STAGES+1 edges after the first sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      history <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], boton};
      history <= sync_out;
      press   <= sync_out & ~history;
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// entry_sequencer
// Steps the user through NUM_OPERANDS operands of DIGITS digits each with a
// single push-button, strobing loaddata once per accepted digit, then lets
// the user browse RES_DIGITS result digits.
// Ports:
//   clk             : system clock
//   rst             : asynchronous active-low reset
//   boton           : raw push-button, active-high
//   inputdata_ready : datapath can accept a digit this cycle
//   loaddata        : one-cycle strobe, capture digit at operand_idx/digit_idx
//   operand_idx     : operand currently being entered
//   digit_idx       : digit being entered or displayed
//   result_phase    : high once all operands are loaded
//   rejected        : one-cycle pulse, press ignored because datapath not ready
//   led             : current 1-based step number
module entry_sequencer
  import entry_seq_pkg::*;
#(
  parameter int NUM_OPERANDS = 2,
  parameter int DIGITS       = 4,
  parameter int RES_DIGITS   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LED_W        = 4,
  localparam int OP_W    = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
  localparam int DIG_MAX = (DIGITS > RES_DIGITS) ? DIGITS : RES_DIGITS,
  localparam int DIG_W   = (DIG_MAX > 1) ? $clog2(DIG_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boton,
  input  logic             inputdata_ready,
  output logic             loaddata,
  output logic [OP_W-1:0]  operand_idx,
  output logic [DIG_W-1:0] digit_idx,
  output logic             result_phase,
  output logic             rejected,
  output logic [LED_W-1:0] led
);

  if (NUM_OPERANDS < 1 || DIGITS < 1 || RES_DIGITS < 1 || SYNC_STAGES < 2) begin : g_bad_size
    $error("entry_sequencer: size parameters out of range");
  end

  if ((2 ** LED_W) <= (NUM_OPERANDS * DIGITS + RES_DIGITS)) begin : g_led_narrow
    $error("entry_sequencer: LED_W too narrow for the number of steps");
  end

  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);
  localparam logic [DIG_W-1:0] LAST_RES   = DIG_W'(RES_DIGITS - 1);
  localparam logic [OP_W-1:0]  LAST_OP    = OP_W'(NUM_OPERANDS - 1);

  seq_state_e       state;
  seq_state_e       state_next;
  logic             press;
  logic [OP_W-1:0]  op_next;
  logic [DIG_W-1:0] dig_next;
  logic             rej_next;
  logic [LED_W-1:0] led_next;

  button_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_button_edge (
    .clk  (clk),
    .rst  (rst),
    .boton(boton),
    .press(press)
  );

  // Outputs decoded straight from the state register so an asynchronous
  // reset drops loaddata immediately.
  assign loaddata     = (state == LOAD_STROBE);
  assign result_phase = (state == RESULT);

  // Indices advance on leaving LOAD_STROBE, so during the strobe they still
  // address the digit being captured. A press during LOAD_STROBE is dropped.
  always_comb begin
    state_next = state;
    op_next    = operand_idx;
    dig_next   = digit_idx;
    rej_next   = 1'b0;
    case (state)
      LOAD_WAIT: begin
        if (press) begin
          if (inputdata_ready) begin
            state_next = LOAD_STROBE;
          end else begin
            rej_next = 1'b1;
          end
        end
      end
      LOAD_STROBE: begin
        if (digit_idx != LAST_DIGIT) begin
          dig_next   = digit_idx + 1'b1;
          state_next = LOAD_WAIT;
        end else begin
          dig_next = '0;
          if (operand_idx != LAST_OP) begin
            op_next    = operand_idx + 1'b1;
            state_next = LOAD_WAIT;
          end else begin
            state_next = RESULT;
          end
        end
      end
      RESULT: begin
        if (press) begin
          dig_next = (digit_idx == LAST_RES) ? '0 : digit_idx + 1'b1;
        end
      end
      default: begin
        state_next = LOAD_WAIT;
      end
    endcase
    led_next = LED_W'(led_step(state_next == RESULT, 32'(op_next), 32'(dig_next),
                               DIGITS, NUM_OPERANDS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD_WAIT;
      operand_idx <= '0;
      digit_idx   <= '0;
      rejected    <= 1'b0;
      led         <= LED_W'(1);
    end else begin
      state       <= state_next;
      operand_idx <= op_next;
      digit_idx   <= dig_next;
      rejected    <= rej_next;
      led         <= led_next;
    end
  end

endmodule

// File: tb/tb_entry_sequencer.sv
// tb_entry_sequencer
// Self-checking bench for entry_sequencer: a default-sized instance (2x4
// digits, 4 result digits) and a 3x2 / 3 result digit instance. Expected
// loads are queued per press and compared when loaddata fires.
module tb_entry_sequencer;

  typedef struct {
    int op;
    int dig;
  } load_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-sized instance
  logic       rst_a = 1'b0;
  logic       boton_a = 1'b0;
  logic       rdy_a = 1'b1;
  logic       ld_a;
  logic [0:0] op_a;
  logic [1:0] dig_a;
  logic       res_a;
  logic       rej_a;
  logic [3:0] led_a;

  // 3 operands x 2 digits, 3 result digits
  logic       rst_b = 1'b0;
  logic       boton_b = 1'b0;
  logic       rdy_b = 1'b1;
  logic       ld_b;
  logic [1:0] op_b;
  logic [1:0] dig_b;
  logic       res_b;
  logic       rej_b;
  logic [3:0] led_b;

  entry_sequencer #(
    .NUM_OPERANDS(2), .DIGITS(4), .RES_DIGITS(4), .SYNC_STAGES(2), .LED_W(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .boton(boton_a), .inputdata_ready(rdy_a),
    .loaddata(ld_a), .operand_idx(op_a), .digit_idx(dig_a),
    .result_phase(res_a), .rejected(rej_a), .led(led_a)
  );

  entry_sequencer #(
    .NUM_OPERANDS(3), .DIGITS(2), .RES_DIGITS(3), .SYNC_STAGES(2), .LED_W(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .boton(boton_b), .inputdata_ready(rdy_b),
    .loaddata(ld_b), .operand_idx(op_b), .digit_idx(dig_b),
    .result_phase(res_b), .rejected(rej_b), .led(led_b)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  load_t q_a[$];
  load_t q_b[$];
  load_t exp_a;
  load_t exp_b;

  int  ma_op = 0, ma_dig = 0;
  bit  ma_res = 1'b0;
  int  mb_op = 0, mb_dig = 0;
  bit  mb_res = 1'b0;

  // Scoreboard model of one press on instance A (2 operands x 4 digits).
  task automatic a_expect(input bit ready);
    if (ma_res) begin
      ma_dig = (ma_dig + 1) % 4;
    end else if (ready) begin
      q_a.push_back('{ma_op, ma_dig});
      if (ma_dig < 3) ma_dig++;
      else begin
        ma_dig = 0;
        if (ma_op < 1) ma_op++;
        else ma_res = 1'b1;
      end
    end
  endtask

  // Scoreboard model of one press on instance B (3 operands x 2 digits).
  task automatic b_expect(input bit ready);
    if (mb_res) begin
      mb_dig = (mb_dig + 1) % 3;
    end else if (ready) begin
      q_b.push_back('{mb_op, mb_dig});
      if (mb_dig < 1) mb_dig++;
      else begin
        mb_dig = 0;
        if (mb_op < 2) mb_op++;
        else mb_res = 1'b1;
      end
    end
  endtask

  function automatic int a_led();
    return ma_res ? (8 + ma_dig + 1) : (ma_op * 4 + ma_dig + 1);
  endfunction

  // Plays a button waveform (bit 0 first, one bit per cycle) and counts
  // loaddata / rejected pulses seen during the window.
  task automatic drive_a(input logic [7:0] pat, input bit ready,
                         output int n_ld, output int n_rej);
    n_ld = 0;
    n_rej = 0;
    rdy_a = ready;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ld_a === 1'b1) n_ld++;
      if (rej_a === 1'b1) n_rej++;
      boton_a = (i < 8) ? pat[i] : 1'b0;
    end
  endtask

  task automatic drive_b(input logic [7:0] pat, input bit ready,
                         output int n_ld, output int n_rej);
    n_ld = 0;
    n_rej = 0;
    rdy_b = ready;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ld_b === 1'b1) n_ld++;
      if (rej_b === 1'b1) n_rej++;
      boton_b = (i < 8) ? pat[i] : 1'b0;
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    boton_a = 1'b0;
    rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    ma_op = 0;
    ma_dig = 0;
    ma_res = 1'b0;
    q_a.delete();
    @(negedge clk);
  endtask

  // loaddata monitors: every strobe must match the oldest queued load.
  always @(negedge clk) begin
    if (ld_a === 1'b1) begin
      n_compared++;
      if (q_a.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL load_a_unexpected: strobe at op=%0d dig=%0d, required no strobe", op_a, dig_a);
      end else begin
        exp_a = q_a.pop_front();
        if (op_a !== 1'(exp_a.op) || dig_a !== 2'(exp_a.dig)) begin
          n_mismatched++;
          $display("[TB] FAIL load_a_index: got op=%0d dig=%0d, required op=%0d dig=%0d",
                   op_a, dig_a, exp_a.op, exp_a.dig);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ld_b === 1'b1) begin
      n_compared++;
      if (q_b.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL load_b_unexpected: strobe at op=%0d dig=%0d, required no strobe", op_b, dig_b);
      end else begin
        exp_b = q_b.pop_front();
        if (op_b !== 2'(exp_b.op) || dig_b !== 2'(exp_b.dig)) begin
          n_mismatched++;
          $display("[TB] FAIL load_b_index: got op=%0d dig=%0d, required op=%0d dig=%0d",
                   op_b, dig_b, exp_b.op, exp_b.dig);
        end
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({led_a, ld_a, res_a, rej_a, op_a, dig_a} !== {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_a: got led=%0d ld=%b res=%b rej=%b op=%0d dig=%0d, required led=1 rest 0",
               led_a, ld_a, res_a, rej_a, op_a, dig_a);
    end
    n_compared++;
    if ({led_b, ld_b, res_b, rej_b, op_b, dig_b} !== {4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_b: got led=%0d ld=%b res=%b rej=%b op=%0d dig=%0d, required led=1 rest 0",
               led_b, ld_b, res_b, rej_b, op_b, dig_b);
    end
  endtask

  // Button held for 20 cycles: one strobe, after edge SYNC_STAGES+1 = 3.
  task automatic test_hold_latency();
    int first_k;
    int n_ld;
    first_k = -1;
    n_ld = 0;
    a_expect(1'b1);
    rdy_a = 1'b1;
    @(negedge clk);
    boton_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ld_a === 1'b1) begin
        n_ld++;
        if (first_k < 0) first_k = k;
      end
    end
    boton_a = 1'b0;
    repeat (4) @(negedge clk);
    n_compared++;
    if (first_k != 3) begin
      n_mismatched++;
      $display("[TB] FAIL hold_latency: strobe after edge %0d, required 3", first_k);
    end
    n_compared++;
    if (n_ld != 1) begin
      n_mismatched++;
      $display("[TB] FAIL hold_single: got %0d strobes, required 1", n_ld);
    end
    n_compared++;
    if (led_a !== 4'(a_led())) begin
      n_mismatched++;
      $display("[TB] FAIL hold_led: got %0d, required %0d", led_a, a_led());
    end
  endtask

  task automatic test_reject();
    int n_ld, n_rej;
    a_expect(1'b1);
    drive_a(8'b0000_0111, 1'b1, n_ld, n_rej);
    n_compared++;
    if (led_a !== 4'd3) begin
      n_mismatched++;
      $display("[TB] FAIL reject_pre_led: got %0d, required 3", led_a);
    end
    a_expect(1'b0);
    drive_a(8'b0000_0111, 1'b0, n_ld, n_rej);
    n_compared++;
    if (n_rej != 1 || n_ld != 0 || led_a !== 4'd3) begin
      n_mismatched++;
      $display("[TB] FAIL reject_pulse: got rej=%0d ld=%0d led=%0d, required rej=1 ld=0 led=3",
               n_rej, n_ld, led_a);
    end
    a_expect(1'b1);
    drive_a(8'b0000_0111, 1'b1, n_ld, n_rej);
    n_compared++;
    if (n_rej != 0 || n_ld != 1 || led_a !== 4'd4) begin
      n_mismatched++;
      $display("[TB] FAIL reject_retry: got rej=%0d ld=%0d led=%0d, required rej=0 ld=1 led=4",
               n_rej, n_ld, led_a);
    end
  endtask

  // A bounce (1,0,1) is two presses and must give two strobes.
  task automatic test_back_to_back();
    int n_ld, n_rej;
    a_expect(1'b1);
    a_expect(1'b1);
    drive_a(8'b0000_0101, 1'b1, n_ld, n_rej);
    n_compared++;
    if (n_ld != 2 || led_a !== 4'd6) begin
      n_mismatched++;
      $display("[TB] FAIL bounce: got ld=%0d led=%0d, required ld=2 led=6", n_ld, led_a);
    end
  endtask

  task automatic test_reset_during_strobe();
    bit found;
    found = 1'b0;
    a_expect(1'b1);
    rdy_a = 1'b1;
    @(negedge clk);
    boton_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ld_a === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_compared++;
    if (!found) begin
      n_mismatched++;
      $display("[TB] FAIL strobe_timeout: got no strobe in 10 cycles, required one");
    end else begin
      #1 rst_a = 1'b0;
      #1;
      if (ld_a !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_async_drop: got ld=%b, required 0", ld_a);
      end
    end
    rst_a = 1'b0;
    boton_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    ma_op = 0;
    ma_dig = 0;
    ma_res = 1'b0;
    q_a.delete();
    @(negedge clk);
    n_compared++;
    if ({led_a, op_a, dig_a, res_a} !== {4'd1, 1'b0, 2'd0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_recover: got led=%0d op=%0d dig=%0d res=%b, required 1/0/0/0",
               led_a, op_a, dig_a, res_a);
    end
  endtask

  task automatic test_full_entry();
    int n_ld, n_rej;
    reset_a();
    for (int i = 0; i < 8; i++) begin
      a_expect(1'b1);
      drive_a(8'b0000_0111, 1'b1, n_ld, n_rej);
      n_compared++;
      if (n_ld != 1 || led_a !== 4'((i < 7) ? i + 2 : 9)) begin
        n_mismatched++;
        $display("[TB] FAIL entry_step%0d: got ld=%0d led=%0d, required ld=1 led=%0d",
                 i, n_ld, led_a, (i < 7) ? i + 2 : 9);
      end
    end
    n_compared++;
    if (res_a !== 1'b1 || op_a !== 1'b1 || dig_a !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL entry_result: got res=%b op=%0d dig=%0d, required res=1 op=1 dig=0",
               res_a, op_a, dig_a);
    end
  endtask

  task automatic test_result_browse();
    int n_ld, n_rej;
    int exp_led[5] = '{10, 11, 12, 9, 10};
    for (int i = 0; i < 5; i++) begin
      a_expect(i != 2);
      drive_a(8'b0000_0111, (i != 2), n_ld, n_rej);
      n_compared++;
      if (n_ld != 0 || n_rej != 0 || led_a !== 4'(exp_led[i]) || res_a !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL result_step%0d: got ld=%0d rej=%0d led=%0d res=%b, required ld=0 rej=0 led=%0d res=1",
                 i, n_ld, n_rej, led_a, res_a, exp_led[i]);
      end
    end
  endtask

  task automatic test_alt_config();
    int n_ld, n_rej;
    int exp_res[4] = '{8, 9, 7, 8};
    for (int i = 0; i < 6; i++) begin
      b_expect(1'b1);
      drive_b(8'b0000_0111, 1'b1, n_ld, n_rej);
      n_compared++;
      if (n_ld != 1 || led_b !== 4'(i + 2)) begin
        n_mismatched++;
        $display("[TB] FAIL alt_entry%0d: got ld=%0d led=%0d, required ld=1 led=%0d",
                 i, n_ld, led_b, i + 2);
      end
    end
    n_compared++;
    if (res_b !== 1'b1 || op_b !== 2'd2) begin
      n_mismatched++;
      $display("[TB] FAIL alt_result: got res=%b op=%0d, required res=1 op=2", res_b, op_b);
    end
    for (int i = 0; i < 4; i++) begin
      b_expect(1'b1);
      drive_b(8'b0000_0111, 1'b1, n_ld, n_rej);
      n_compared++;
      if (n_ld != 0 || led_b !== 4'(exp_res[i])) begin
        n_mismatched++;
        $display("[TB] FAIL alt_browse%0d: got ld=%0d led=%0d, required ld=0 led=%0d",
                 i, n_ld, led_b, exp_res[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] entry_sequencer bench start");
    test_reset();
    test_hold_latency();
    test_reject();
    test_back_to_back();
    test_reset_during_strobe();
    test_full_entry();
    test_result_browse();
    test_alt_config();
    repeat (2) @(negedge clk);
    n_compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL missing_loads: got %0d/%0d loads outstanding, required 0/0",
               q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
